// File: rtl/qar_mem_wait_model_if.sv
// qar_core mem_* bus: valid/ready request-response handshake.
// Master holds the request until mem_ready; slave strobes mem_ready once.
interface qar_mem_wait_model_if #(
  parameter int DATA_WIDTH = 32
) ();
  localparam int NB = DATA_WIDTH / 8;

  logic                  mem_valid;
  logic                  mem_we;
  logic [NB-1:0]         mem_wstrb;
  logic [31:0]           mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_ready;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  mem_err;

  modport master (
    output mem_valid,
    output mem_we,
    output mem_wstrb,
    output mem_addr,
    output mem_wdata,
    input  mem_ready,
    input  mem_rdata,
    input  mem_err
  );

  modport slave (
    input  mem_valid,
    input  mem_we,
    input  mem_wstrb,
    input  mem_addr,
    input  mem_wdata,
    output mem_ready,
    output mem_rdata,
    output mem_err
  );
endinterface

// File: rtl/qar_mem_wait_model.sv
// Data-memory slave with fixed or LFSR-random wait states,
// byte strobes, range/alignment errors and traffic counters.
module qar_mem_wait_model #(
  parameter int          DEPTH_LOG2    = 8,
  parameter int          DATA_WIDTH    = 32,
  parameter logic [31:0] BASE_ADDR     = 32'h0000_0000,
  parameter int          LAT_MODE      = 1,
  parameter int          FIXED_WAIT    = 0,
  parameter int          MAX_WAIT_LOG2 = 2,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall_en,
  qar_mem_wait_model_if.slave   bus,
  output logic [15:0]           stat_req_count,
  output logic [31:0]           stat_wait_cycles
);
  localparam int NB    = DATA_WIDTH / 8;
  localparam int LB    = $clog2(NB);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [15:0] SEED =
    (LFSR_SEED == 16'h0) ? 16'h0001 : LFSR_SEED;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t                state;
  logic [7:0]            cnt;
  logic                  we_q;
  logic [NB-1:0]         strb_q;
  logic [31:0]           addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [15:0]           lfsr;
  logic [15:0]           lfsr_nx;
  logic [7:0]            w_next;
  logic [31:0]           off;
  logic [DEPTH_LOG2-1:0] idx;
  logic                  bad;
  logic                  do_acc;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  assign lfsr_nx = {1'b0, lfsr[15:1]}
                 ^ (lfsr[0] ? 16'hB400 : 16'h0000);

  always_comb begin
    w_next = 8'd0;
    if (stall_en) begin
      if (LAT_MODE != 0)
        w_next = 8'(lfsr[MAX_WAIT_LOG2-1:0]);
      else
        w_next = 8'(FIXED_WAIT);
    end
  end

  // Below-base addresses wrap to huge offsets and fail the range test.
  assign off = addr_q - BASE_ADDR;
  assign idx = DEPTH_LOG2'(off >> LB);
  assign bad = ((off & 32'(NB - 1)) != 32'd0)
             | ((off >> (LB + DEPTH_LOG2)) != 32'd0);
  assign do_acc = (state == WAIT) && (cnt == 8'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      cnt              <= 8'd0;
      we_q             <= 1'b0;
      strb_q           <= '0;
      addr_q           <= 32'd0;
      wdata_q          <= '0;
      bus.mem_ready    <= 1'b0;
      bus.mem_err      <= 1'b0;
      bus.mem_rdata    <= '0;
      stat_req_count   <= 16'd0;
      stat_wait_cycles <= 32'd0;
      lfsr             <= SEED;
    end else begin
      lfsr          <= lfsr_nx;
      bus.mem_ready <= 1'b0;
      bus.mem_err   <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.mem_valid) begin
            we_q    <= bus.mem_we;
            strb_q  <= bus.mem_wstrb;
            addr_q  <= bus.mem_addr;
            wdata_q <= bus.mem_wdata;
            cnt     <= w_next;
            state   <= WAIT;
          end
        end
        WAIT: begin
          if (cnt != 8'd0) begin
            cnt <= cnt - 8'd1;
            if (stat_wait_cycles != 32'hFFFF_FFFF)
              stat_wait_cycles <= stat_wait_cycles + 32'd1;
          end else begin
            bus.mem_ready <= 1'b1;
            bus.mem_err   <= bad;
            if (bad)
              bus.mem_rdata <= '0;
            else if (!we_q)
              bus.mem_rdata <= mem[idx];
            if (stat_req_count != 16'hFFFF)
              stat_req_count <= stat_req_count + 16'd1;
            state <= RESP;
          end
        end
        RESP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && do_acc && we_q && !bad) begin
      for (int b = 0; b < NB; b++)
        if (strb_q[b])
          mem[idx][8*b +: 8] <= wdata_q[8*b +: 8];
    end
  end
endmodule
